// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 codes, FSM encoding,
// and store lane helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  function automatic logic [3:0] store_strobe(input logic [2:0] funct3, input logic [1:0] offset);
    case (funct3)
      F3_B:    return 4'b0001 << offset;
      F3_H:    return 4'b0011 << {offset[1], 1'b0};
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Replicate the store operand across every lane so the strobes alone pick the bytes.
  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      F3_B:    return {4{wdata[7:0]}};
      F3_H:    return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte/half lane selection and sign/zero extension of a loaded word.
import mem_pkg::*;

module load_extend (
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (offset)
      2'd0:    byte_lane = rdata[7:0];
      2'd1:    byte_lane = rdata[15:8];
      2'd2:    byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    result = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    result = {{16{half_lane[15]}}, half_lane};
      F3_BU:   result = {24'h000000, byte_lane};
      F3_HU:   result = {16'h0000, half_lane};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: request/ready handshake with data memory, lane steering,
// load extension and pipeline stall generation.
import mem_pkg::*;

module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallMem,
  output logic        AccessFaultM,
  output logic        BusErrM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic [1:0]           offset_p1;
  logic [2:0]           funct3_p1;
  logic                 op, bad_funct3, misaligned, start, timeout;
  logic [31:0]          load_result;

  always_comb begin
    op = MemWriteM | MemReadM;
    if (MemWriteM)
      bad_funct3 = !(Funct3M inside {F3_B, F3_H, F3_W});
    else
      bad_funct3 = Funct3M inside {3'b011, 3'b110, 3'b111};
    misaligned = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                 ((Funct3M == F3_W) && (ALUResultM[1:0] != 2'b00));
    AccessFaultM = op & (bad_funct3 | misaligned);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    StallMem   = 1'b0;
    start      = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (op && !AccessFaultM) begin
          StallMem   = 1'b1;
          start      = 1'b1;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        StallMem = 1'b1;
        if (mem_ready) begin
          state_next = ST_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (wait_cnt == CNT_LAST)) begin
          timeout    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    // A reset that lands mid-access must release the pipeline at once.
    if (reset) StallMem = 1'b0;
  end

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .offset (offset_p1),
    .funct3 (funct3_p1),
    .result (load_result)
  );

  // Request capture (IDLE -> ACCESS) and completion/abort (ACCESS -> DONE)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      ReadDataM <= '0;
      BusErrM   <= 1'b0;
      wait_cnt  <= '0;
      offset_p1 <= '0;
      funct3_p1 <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {ALUResultM[31:2], 2'b00};
            mem_wdata <= MemWriteM ? store_data(Funct3M, WriteDataM) : 32'h0;
            mem_wstrb <= MemWriteM ? store_strobe(Funct3M, ALUResultM[1:0]) : 4'b0000;
            offset_p1 <= ALUResultM[1:0];
            funct3_p1 <= Funct3M;
            wait_cnt  <= '0;
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) ReadDataM <= load_result;
          end else if (timeout) begin
            mem_req   <= 1'b0;
            ReadDataM <= '0;
            BusErrM   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE:  BusErrM <= 1'b0;
        default:  BusErrM <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: the bench plays the data memory and a scoreboard
// queue holds the load result expected when each access reaches DONE.
module tb_mem_access_unit;

  logic        clock, reset;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallMem, AccessFaultM, BusErrM;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  typedef struct {
    logic [31:0] rd;
    logic        berr;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_rd = 32'h0;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .MemReadM     (MemReadM),
    .MemWriteM    (MemWriteM),
    .Funct3M      (Funct3M),
    .ALUResultM   (ALUResultM),
    .WriteDataM   (WriteDataM),
    .ReadDataM    (ReadDataM),
    .StallMem     (StallMem),
    .AccessFaultM (AccessFaultM),
    .BusErrM      (BusErrM),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete access with the bench acting as memory; ready after 'waits' wait cycles.
  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int waits, input logic [31:0] exp_rd, input logic exp_berr,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                        input int exp_stall, input int exp_req);
    exp_t e;
    int   n, w, reqc;
    bit   first;
    e.rd   = exp_rd;
    e.berr = exp_berr;
    sb.push_back(e);
    @(negedge clock);
    MemWriteM  = we;
    MemReadM   = !we;
    Funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = wd;
    mem_ready  = 1'b0;
    #1;
    check({tag, "_nofault"}, AccessFaultM, 1'b0);
    n = 0; w = 0; reqc = 0; first = 1'b1;
    while (StallMem && n < 60) begin
      if (mem_req) begin
        reqc++;
        if (first) begin
          first = 1'b0;
          check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
          check({tag, "_we"}, mem_we, we);
          check({tag, "_wstrb"}, mem_wstrb, exp_strb);
          if (we) check({tag, "_wdata"}, mem_wdata, exp_wdata);
        end
        mem_ready = (w == waits);
        mem_rdata = rdata;
        w++;
      end
      n++;
      @(negedge clock);
    end
    check({tag, "_stall_cycles"}, n, exp_stall);
    check({tag, "_req_cycles"}, reqc, exp_req);
    check({tag, "_req_done"}, mem_req, 1'b0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      check({tag, "_rdata"}, ReadDataM, e.rd);
      check({tag, "_buserr"}, BusErrM, e.berr);
    end
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
    mem_ready = 1'b0;
    @(negedge clock);
    check({tag, "_buserr_clr"}, BusErrM, 1'b0);
    check({tag, "_idle_stall"}, StallMem, 1'b0);
    last_rd = exp_rd;
  endtask

  task automatic fault_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr);
    @(negedge clock);
    MemWriteM  = we;
    MemReadM   = !we;
    Funct3M    = f3;
    ALUResultM = addr;
    WriteDataM = 32'h55AA55AA;
    #1;
    check({tag, "_fault"}, AccessFaultM, 1'b1);
    check({tag, "_stall"}, StallMem, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check({tag, "_noreq"}, mem_req, 1'b0);
    end
    check({tag, "_rd_hold"}, ReadDataM, last_rd);
    MemReadM  = 1'b0;
    MemWriteM = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    MemReadM = 1'b0; MemWriteM = 1'b0; Funct3M = 3'b000;
    ALUResultM = 32'h0; WriteDataM = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    #12;
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_wstrb", mem_wstrb, 4'h0);
    check("rst_rdata", ReadDataM, 32'h0);
    check("rst_buserr", BusErrM, 1'b0);
    check("rst_stall", StallMem, 1'b0);
    @(negedge clock);
    reset = 1'b0;

    // mem_ready while idle must not start or complete anything
    @(negedge clock);
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clock);
    check("idle_ready_req", mem_req, 1'b0);
    check("idle_ready_rd", ReadDataM, 32'h0);
    mem_ready = 1'b0;

    run_op("lw",  1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0, 2, 1);
    run_op("lb",  1'b0, 3'b000, 32'h203, 32'h0, 32'h80FFFFFF, 0, 32'hFFFFFF80, 1'b0, 4'h0, 32'h0, 2, 1);
    run_op("lbu", 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FFFFFF, 0, 32'h00000080, 1'b0, 4'h0, 32'h0, 2, 1);
    run_op("lhu", 1'b0, 3'b101, 32'h202, 32'h0, 32'h80FFFFFF, 0, 32'h000080FF, 1'b0, 4'h0, 32'h0, 2, 1);
    run_op("lh",  1'b0, 3'b001, 32'h202, 32'h0, 32'h80FFFFFF, 2, 32'hFFFF80FF, 1'b0, 4'h0, 32'h0, 4, 3);
    run_op("lb0", 1'b0, 3'b000, 32'h204, 32'h0, 32'h1122337F, 1, 32'h0000007F, 1'b0, 4'h0, 32'h0, 3, 2);
    run_op("sb",  1'b1, 3'b000, 32'h301, 32'h000000A5, 32'hFFFFFFFF, 0, 32'h0000007F, 1'b0,
           4'b0010, 32'hA5A5A5A5, 2, 1);
    run_op("sh",  1'b1, 3'b001, 32'h302, 32'h00001234, 32'hFFFFFFFF, 0, 32'h0000007F, 1'b0,
           4'b1100, 32'h12341234, 2, 1);
    run_op("sw",  1'b1, 3'b010, 32'h304, 32'hCAFEF00D, 32'hFFFFFFFF, 1, 32'h0000007F, 1'b0,
           4'b1111, 32'hCAFEF00D, 3, 2);

    fault_op("lw_mis",  1'b0, 3'b010, 32'h102);
    fault_op("sh_mis",  1'b1, 3'b001, 32'h301);
    fault_op("ld_f3",   1'b0, 3'b011, 32'h100);
    fault_op("st_f3",   1'b1, 3'b100, 32'h100);

    // memory never answers: four request cycles, then a bus-error abort
    run_op("tmo", 1'b0, 3'b010, 32'h500, 32'h0, 32'h0BADF00D, 100, 32'h0, 1'b1, 4'h0, 32'h0, 5, 4);

    // reset while waiting in ACCESS, then a clean access afterwards
    @(negedge clock);
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h400; mem_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_mid_req_before", mem_req, 1'b1);
    check("rst_mid_stall_before", StallMem, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_mid_req", mem_req, 1'b0);
    check("rst_mid_stall", StallMem, 1'b0);
    check("rst_mid_rd", ReadDataM, 32'h0);
    @(negedge clock);
    MemReadM = 1'b0;
    reset = 1'b0;
    last_rd = 32'h0;
    run_op("lw_after_rst", 1'b0, 3'b010, 32'h400, 32'h0, 32'h13579BDF, 0, 32'h13579BDF, 1'b0,
           4'h0, 32'h0, 2, 1);

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
